// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT,
        FIN
    } state_t;

    localparam int TAPS   = 9;
    localparam int KSIZE  = 3;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 9;
    localparam int PROD_W = 17;

endpackage

// File: rtl/conv_addr_gen.sv
// Window/tap address generator: window origin and in-window tap offset are
// tracked incrementally, so the pixel address never needs a multiply or divide.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int PIX_ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_tap_step,
    input  logic                       i_win_step,
    output logic [PIX_ADDR_W-1:0]      o_pix_addr,
    output logic [3:0]                 o_coef_addr,
    output logic [$clog2(IMG_H)-1:0]   o_row,
    output logic [$clog2(IMG_W)-1:0]   o_col,
    output logic                       o_last_tap,
    output logic                       o_last_window
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [1:0]            r_trow;
    logic [1:0]            r_tcol;
    logic [3:0]            r_k;
    logic [PIX_ADDR_W-1:0] r_base;
    logic [PIX_ADDR_W-1:0] r_off;

    assign o_last_tap    = (r_k == 4'(TAPS - 1));
    assign o_last_window = (r_row == RW'(IMG_H - KSIZE)) && (r_col == CW'(IMG_W - KSIZE));
    assign o_pix_addr    = r_base + r_off;
    assign o_coef_addr   = r_k;
    assign o_row         = r_row;
    assign o_col         = r_col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_trow <= '0;
            r_tcol <= '0;
            r_k    <= '0;
            r_base <= '0;
            r_off  <= '0;
        end else if (i_clear) begin
            r_row  <= '0;
            r_col  <= '0;
            r_trow <= '0;
            r_tcol <= '0;
            r_k    <= '0;
            r_base <= '0;
            r_off  <= '0;
        end else begin
            // Tap walk: the last tap wraps back to 0 ready for the next window
            if (i_tap_step) begin
                if (o_last_tap) begin
                    r_trow <= '0;
                    r_tcol <= '0;
                    r_k    <= '0;
                    r_off  <= '0;
                end else if (r_tcol == 2'(KSIZE - 1)) begin
                    r_trow <= r_trow + 2'(1);
                    r_tcol <= '0;
                    r_k    <= r_k + 4'(1);
                    r_off  <= r_off + PIX_ADDR_W'(IMG_W - KSIZE + 1);
                end else begin
                    r_tcol <= r_tcol + 2'(1);
                    r_k    <= r_k + 4'(1);
                    r_off  <= r_off + PIX_ADDR_W'(1);
                end
            end
            if (i_win_step) begin
                if (r_col == CW'(IMG_W - KSIZE)) begin
                    r_col  <= '0;
                    r_row  <= r_row + RW'(1);
                    r_base <= r_base + PIX_ADDR_W'(KSIZE);
                end else begin
                    r_col  <= r_col + CW'(1);
                    r_base <= r_base + PIX_ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Sequences a full valid-mode 3x3 convolution pass: nine ROM/pixel reads per
// window, a 9-tap MAC, and one signed result per window on a valid/ready stream.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int PIX_ADDR_W = 10,
    parameter int ACC_W      = 21
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    output logic                            coef_en,
    output logic [3:0]                      coef_addr,
    input  logic signed [COEF_W-1:0]        coef_data,
    output logic                            pix_en,
    output logic [PIX_ADDR_W-1:0]           pix_addr,
    input  logic [PIX_W-1:0]                pix_data,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic signed [ACC_W-1:0]         res_data,
    output logic [$clog2(IMG_H)-1:0]        res_row,
    output logic [$clog2(IMG_W)-1:0]        res_col
);

    state_t r_state, w_next;

    logic w_last_tap, w_last_win;
    logic w_clear, w_tap_step, w_win_step, w_acc_clr, w_rd_en;
    logic r_rd_d;

    logic signed [PROD_W-1:0] w_pix_x, w_coef_x, w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext, r_acc, r_res_data;

    conv_addr_gen #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .PIX_ADDR_W (PIX_ADDR_W)
    ) u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_clear),
        .i_tap_step    (w_tap_step),
        .i_win_step    (w_win_step),
        .o_pix_addr    (pix_addr),
        .o_coef_addr   (coef_addr),
        .o_row         (res_row),
        .o_col         (res_col),
        .o_last_tap    (w_last_tap),
        .o_last_window (w_last_win)
    );

    assign w_rd_en   = (r_state == FETCH);
    assign coef_en   = w_rd_en;
    assign pix_en    = w_rd_en;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIN);
    assign res_valid = (r_state == OUT);
    assign res_data  = r_res_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_tap_step = 1'b0;
        w_win_step = 1'b0;
        w_acc_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next    = FETCH;
                    w_clear   = 1'b1;
                    w_acc_clr = 1'b1;
                end
            end
            FETCH: begin
                w_tap_step = 1'b1;
                if (w_last_tap) w_next = DRAIN;
            end
            DRAIN: w_next = OUT;
            OUT: begin
                if (res_ready) begin
                    if (w_last_win) begin
                        w_next = FIN;
                    end else begin
                        w_next     = FETCH;
                        w_win_step = 1'b1;
                        w_acc_clr  = 1'b1;
                    end
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Abort cancels any in-flight work; counters are re-cleared by the next start
        if (abort && (r_state != IDLE)) begin
            w_next     = IDLE;
            w_tap_step = 1'b0;
            w_win_step = 1'b0;
            w_acc_clr  = 1'b0;
        end
    end

    // Pixel is unsigned, so it is zero-extended before the signed multiply
    assign w_pix_x    = PROD_W'(pix_data);
    assign w_coef_x   = PROD_W'(coef_data);
    assign w_prod     = w_pix_x * w_coef_x;
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_d     <= 1'b0;
            r_acc      <= '0;
            r_res_data <= '0;
        end else begin
            r_rd_d <= w_rd_en;
            if (w_acc_clr)   r_acc <= '0;
            else if (r_rd_d) r_acc <= r_acc + w_prod_ext;
            if (r_state == DRAIN) r_res_data <= r_acc + w_prod_ext;
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized bench for conv_window_sequencer on a 5x5 image with a direct
// convolution reference model and behavioural ROM/pixel-buffer models.
module tb_conv_window_sequencer;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int AW   = 5;
    localparam int ACC  = 21;
    localparam int OW   = W - 2;
    localparam int NWIN = (W - 2) * (H - 2);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic                  busy, done, coef_en, pix_en, res_valid;
    logic                  res_ready = 1'b0;
    logic [3:0]            coef_addr;
    logic signed [8:0]     coef_data = '0;
    logic [AW-1:0]         pix_addr;
    logic [7:0]            pix_data = '0;
    logic signed [ACC-1:0] res_data;
    logic [2:0]            res_row, res_col;

    int     n_checks = 0;
    int     n_errors = 0;
    int     img[32];
    int     rom[16];
    longint obs[NWIN];

    conv_window_sequencer #(
        .IMG_W(W), .IMG_H(H), .PIX_ADDR_W(AW), .ACC_W(ACC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .coef_en(coef_en), .coef_addr(coef_addr), .coef_data(coef_data),
        .pix_en(pix_en), .pix_addr(pix_addr), .pix_data(pix_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency memories; junk is returned when not enabled
    always @(posedge clk) begin
        coef_data <= coef_en ? 9'(rom[coef_addr]) : 9'($urandom);
        pix_data  <= pix_en  ? 8'(img[pix_addr])  : 8'($urandom);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_win(input int r, input int c);
        longint s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += longint'(img[(r + i) * W + c + j]) * longint'(rom[i * 3 + j]);
        return s;
    endfunction

    task automatic check_zero(input string p);
        check({p, "_busy"},  busy, 0);
        check({p, "_done"},  done, 0);
        check({p, "_en"},    {coef_en, pix_en}, 0);
        check({p, "_valid"}, res_valid, 0);
        check({p, "_caddr"}, coef_addr, 0);
        check({p, "_paddr"}, pix_addr, 0);
        check({p, "_data"},  res_data, 0);
        check({p, "_row"},   res_row, 0);
        check({p, "_col"},   res_col, 0);
    endtask

    task automatic set_laplacian();
        for (int i = 0; i < 16; i++) rom[i] = 0;
        rom[1] = -1; rom[3] = -1; rom[4] = 4; rom[5] = -1; rom[7] = -1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 32; i++) img[i] = (i < W * H) ? int'($urandom_range(0, 255)) : 0;
        for (int i = 0; i < 16; i++) rom[i] = (i < 9) ? int'($urandom_range(0, 511)) - 256 : 0;
    endtask

    task automatic fill_img(input int v);
        for (int i = 0; i < 32; i++) img[i] = (i < W * H) ? v : 0;
    endtask

    task automatic run_pass(input bit rand_ready, input int stall_idx, input int stall_len,
                            input bit rand_start, input int abort_idx, input int rst_idx,
                            input bit abort_with_start, input bit chk_timing);
        int     idx = 0, cyc = 0, stall = 0, first_v = -1, last_x = -1, done_cnt = 0;
        bit     hold = 0, stop = 0;
        longint h_data;
        int     h_row = 0, h_col = 0;
        @(negedge clk);
        start = 1'b1; abort = abort_with_start; res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        while (!stop && cyc < 3000) begin
            if (res_valid && first_v < 0) begin
                first_v = cyc;
                if (chk_timing) check("first_valid_edge", cyc + 1, 11);
            end
            if (res_valid) check("no_rd_in_out", {coef_en, pix_en}, 0);
            if (hold) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", res_data, h_data);
                check("hold_row", res_row, h_row);
                check("hold_col", res_col, h_col);
            end
            if (abort_idx >= 0 && idx == abort_idx && coef_en && coef_addr == 4'd4) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_valid", res_valid, 0);
                check("abort_en", {coef_en, pix_en}, 0);
                for (int t = 0; t < 15; t++) begin
                    @(negedge clk);
                    if (done) check("abort_no_done", done, 0);
                end
                stop = 1;
            end else if (rst_idx >= 0 && idx == rst_idx && res_valid) begin
                check("pre_rst_row", res_row, 1);
                #2 rst = 1'b0;
                #1 check_zero("async_rst");
                @(negedge clk);
                rst = 1'b1;
                stop = 1;
            end else if (done) begin
                done_cnt++;
                @(negedge clk);
                check("done_one_cycle", done, 0);
                check("idle_after_done", busy, 0);
                stop = 1;
            end else begin
                if (res_valid && idx == stall_idx && stall < stall_len) begin
                    res_ready = 1'b0;
                    stall++;
                end else begin
                    res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                start = (rand_start && idx < NWIN) ? ($urandom_range(0, 5) == 0) : 1'b0;
                hold = 0;
                if (res_valid && res_ready) begin
                    if (idx < NWIN) begin
                        check("res_data", res_data, ref_win(idx / OW, idx % OW));
                        check("res_row", res_row, idx / OW);
                        check("res_col", res_col, idx % OW);
                        obs[idx] = res_data;
                    end
                    if (chk_timing && last_x >= 0) check("window_period", cyc - last_x, 11);
                    last_x = cyc;
                    idx++;
                end else if (res_valid) begin
                    hold = 1; h_data = res_data; h_row = res_row; h_col = res_col;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        res_ready = 1'b0;
        if (abort_idx < 0 && rst_idx < 0) begin
            check("n_results", idx, NWIN);
            check("done_pulses", done_cnt, 1);
        end else begin
            check("stopped_in_time", stop, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < NWIN; i++) obs[i] = 0;
        fill_img(0);
        set_laplacian();
        #3 rst = 1'b0;
        #1 check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        fill_img(10);
        run_pass(0, -1, 0, 0, -1, -1, 0, 1);

        fill_img(0); img[6] = 100;
        run_pass(0, -1, 0, 0, -1, -1, 0, 0);
        check("imp_00", obs[0], 400);
        check("imp_01", obs[1], -100);
        check("imp_10", obs[3], -100);
        check("imp_02", obs[2], 0);
        check("imp_11", obs[4], 0);

        fill_img(0); img[6] = 255;
        run_pass(0, -1, 0, 0, -1, -1, 0, 0);
        check("max_pos_00", obs[0], 1020);
        fill_img(255); img[6] = 0;
        run_pass(0, -1, 0, 0, -1, -1, 0, 0);
        check("max_neg_00", obs[0], -1020);

        randomize_data();
        run_pass(0, 1, 5, 0, -1, -1, 0, 0);

        for (int p = 0; p < 3; p++) begin
            randomize_data();
            run_pass(1, -1, 0, 1, -1, -1, 0, 0);
        end

        randomize_data();
        run_pass(1, -1, 0, 0, 4, -1, 0, 0);
        run_pass(1, -1, 0, 0, -1, -1, 0, 0);

        randomize_data();
        run_pass(0, 5, 3, 0, -1, 5, 0, 0);
        randomize_data();
        run_pass(1, -1, 0, 0, -1, -1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Drives one full 3x3 valid-mode convolution pass over a stored greyscale image.
- For each output position it issues nine coefficient reads to the kernel coefficient ROM (en/addr port, 1-cycle read latency, 9-bit signed data) and nine matching pixel reads to the image buffer.
- It multiply-accumulates the 9 products and presents one signed result per window on a valid/ready stream to the downstream pattern-detection stage.

Parameters:
- IMG_W, 28, image width in pixels (>=3)
- IMG_H, 28, image height in pixels (>=3)
- PIX_ADDR_W, 10, pixel buffer address width; must satisfy 2^PIX_ADDR_W >= IMG_W*IMG_H
- ACC_W, 21, accumulator/result width (17-bit product + 4 growth bits for 9 taps)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  synchronous cancel of the current pass
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted
- coef_en  out  1  read enable to coefficient ROM
- coef_addr  out  4  tap index 0..8 to coefficient ROM
- coef_data  in  9  signed coefficient, valid the cycle after coef_en
- pix_en  out  1  read enable to pixel buffer
- pix_addr  out  PIX_ADDR_W  pixel address, row-major (row*IMG_W+col)
- pix_data  in  8  unsigned pixel, valid the cycle after pix_en
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  ACC_W  signed convolution result
- res_row  out  $clog2(IMG_H)  output row index of res_data
- res_col  out  $clog2(IMG_W)  output column index of res_data

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, done, coef_en, pix_en, res_valid = 0; coef_addr, pix_addr, res_data, res_row, res_col = 0; all counters and the accumulator cleared.
- States: IDLE, FETCH, DRAIN, OUT, FIN.
- IDLE:
  - On start=1: go to FETCH with row=col=0, tap k=0, acc=0.
- FETCH: lasts 9 cycles, k=0..8.
  - coef_en=pix_en=1 and coef_addr=k.
  - pix_addr = (row+k/3)*IMG_W + (col+k%3), generated from tap-row/tap-col counters; no divider.
  - From the second FETCH cycle onward, acc += sign-extended pix_data (zero-extended) * coef_data, i.e. the data of tap k-1.
  - After k=8, go to DRAIN.
- DRAIN: 1 cycle.
  - Enables are 0.
  - Tap 8 product is accumulated; acc is copied to res_data; go to OUT.
- OUT:
  - res_valid=1; res_data, res_row, res_col are held stable until res_ready=1.
  - Transfer occurs in a cycle with res_valid & res_ready.
  - On transfer, if row==IMG_H-3 and col==IMG_W-3, go to FIN.
  - Otherwise advance: col++ (wrapping to 0 with row++ at col==IMG_W-3); acc=0; k=0; go to FETCH.
  - No reads are issued while in OUT.
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency:
  - start sampled at edge 0 → first FETCH cycle follows; res_valid is first high 11 cycles after the start edge.
  - Per-window period is 11 cycles with res_ready tied high.
  - Full pass is (IMG_W-2)*(IMG_H-2) windows.
- Arithmetic: product is 17-bit signed; acc is ACC_W signed; no saturation; two's-complement wrap only if ACC_W is overridden too small.
- Simultaneous events:
  - abort has priority over everything in any non-IDLE state: next cycle IDLE, res_valid/enables drop, done not pulsed, pending result discarded.
  - start while busy is ignored.
  - start and abort both high in IDLE → start wins (abort is a no-op in IDLE).
- Reset mid-pass: immediate return to IDLE values; no done pulse; the next start restarts at window (0,0).
- pix_data/coef_data are ignored in any cycle not following an enable.

Decomposition:
- Package conv_pkg holds:
  - state enum {IDLE, FETCH, DRAIN, OUT, FIN}
  - constants TAPS=9, KSIZE=3, PIX_W=8, COEF_W=9, PROD_W=17
- One sub-module, conv_addr_gen: holds row/col/tap-row/tap-col counters and produces pix_addr, coef_addr, last_tap and last_window flags.
- The FSM and MAC stay in the top.

Test Plan:
- Uniform image, every pixel 10, Laplacian ROM (0,-1,0,-1,4,-1,0,-1,0), IMG_W=IMG_H=5, res_ready=1 → 9 results, all 0, row/col order (0,0)..(2,2); done pulses once; res_valid first high 11 cycles after start.
- Impulse, pixel(1,1)=100 else 0, IMG 5x5 → (0,0)=+400, (0,1)=-100, (1,0)=-100, (0,2)=0, (1,1)=0; all others 0.
- Extremes: pixel(1,1)=255 else 0 → (0,0)=+1020. Pixels all 255 except (1,1)=0 → (0,0)=-1020; sign extension of res_data is checked.
- Backpressure: hold res_ready low 5 cycles at window (0,1) → res_valid stays high, res_data/res_row/res_col stable, coef_en=pix_en=0 throughout; the result transfers on the first ready cycle and the pass completes with correct values.
- abort asserted in FETCH k=4 of window (1,1) → IDLE next cycle, busy=0, no done; a re-start yields a full, correct 9-result pass.
- Async reset deasserted-low mid-OUT → all outputs 0 immediately (not on the next edge); start ignored while busy; start and abort high together in IDLE → pass starts.
